// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N producers share one sync_fifo write port, zero-latency grant.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to BURST_LEN consecutive words.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      din,
    output logic [N-1:0]         ack,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_din,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int ID_W = $clog2(N);

    logic [ID_W-1:0] r_last;
    logic            w_any;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_rr_idx;
    logic [ID_W-1:0] w_cand_idx [N];
    logic [N-1:0]    w_cand_req;
    logic [DW-1:0]   w_word [N];

    assign w_any = |req;

    // Candidate gi is the port gi+1 positions after the last winner, wrapping at N.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            logic [ID_W:0] w_sum;
            assign w_sum            = {1'b0, r_last} + (ID_W+1)'(gi + 1);
            assign w_cand_idx[gi]   = (w_sum >= (ID_W+1)'(N)) ? ID_W'(w_sum - (ID_W+1)'(N))
                                                              : w_sum[ID_W-1:0];
            assign w_cand_req[gi]   = req[w_cand_idx[gi]];
            assign w_word[gi]       = din[gi*DW +: DW];
            assign ack[gi]          = fifo_wr_en & (w_sel == ID_W'(gi));
        end
    endgenerate

    // Lowest rotation offset with an active request wins.
    always_comb begin
        w_rr_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand_req[i]) begin
                w_rr_idx = w_cand_idx[i];
            end
        end
    end

    assign fifo_wr_en = w_any & ~fifo_full & rstn;
    assign fifo_din   = w_any ? w_word[w_sel] : '0;
    assign grant_id   = w_any ? w_sel : '0;

`ifdef FIFO_ARB_BURST_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0] r_st;
    logic [3:0] r_bcnt;
    logic       w_keep;
    logic [3:0] w_cnt_next;

    // The owner keeps the port only while it is still requesting.
    assign w_keep     = (r_st == ST_LOCK) && req[r_last];
    assign w_sel      = w_keep ? r_last : w_rr_idx;
    assign w_cnt_next = w_keep ? (r_bcnt + 4'd1) : 4'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= ID_W'(N - 1);
            r_st   <= ST_IDLE;
            r_bcnt <= 4'd0;
        end else if (fifo_wr_en) begin
            r_last <= w_sel;
            if (w_cnt_next >= 4'(BURST_LEN)) begin
                r_st   <= ST_IDLE;
                r_bcnt <= 4'd0;
            end else begin
                r_st   <= ST_LOCK;
                r_bcnt <= w_cnt_next;
            end
        end else if (!w_any || ((r_st == ST_LOCK) && !req[r_last])) begin
            r_st   <= ST_IDLE;
            r_bcnt <= 4'd0;
        end
    end
`else
    assign w_sel = w_rr_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= ID_W'(N - 1);
        end else if (fifo_wr_en) begin
            r_last <= w_sel;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter plus an end-to-end run against a small FIFO model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int WORDS = 50;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din;
    logic [N-1:0]    ack;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic [1:0]      grant_id;

    logic tb_full    = 1'b0;
    logic model_full = 1'b0;
    logic e2e_mode   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    assign fifo_full = e2e_mode ? model_full : tb_full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(N), .DW(DW), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .din        (din),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id)
    );

    // FIFO model: write/read decisions sampled mid-cycle, applied on the rising edge.
    logic [DW-1:0] q[$];
    int            exp_seq[N];
    logic          s_wr, s_rd;
    logic [DW-1:0] s_din;
    logic [N-1:0]  s_ack;

    always @(negedge clk) begin
        s_wr  = e2e_mode & fifo_wr_en;
        s_din = fifo_din;
        s_ack = ack;
        s_rd  = e2e_mode && ($urandom_range(0, 1) == 1);
    end

    always @(posedge clk) begin
        if (e2e_mode) begin
            if (s_rd && q.size() > 0) begin
                logic [DW-1:0] w;
                w = q.pop_front();
                n_vec++;
                if (int'(w[15:12]) >= N || int'(w[11:0]) != exp_seq[w[15:12]]) begin
                    n_err++;
                    $display("FAIL e2e_order: read word %h, required port<%0d with next seq", w, N);
                end else begin
                    exp_seq[w[15:12]]++;
                end
            end
            if (s_wr) begin
                n_vec++;
                if (int'(s_din[15:12]) >= N || s_ack != (4'b0001 << s_din[15:12])) begin
                    n_err++;
                    $display("FAIL e2e_ack: ack %b with word %h, required ack of word's port", s_ack, s_din);
                end
                q.push_back(s_din);
            end
            model_full <= (q.size() >= DEPTH);
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        int exp_port[5];
`ifdef FIFO_ARB_BURST_EN
        exp_port = '{0, 0, 0, 0, 1};
`else
        exp_port = '{0, 1, 2, 3, 0};
`endif
        rstn    = 1'b0;
        tb_full = 1'b0;
        req     = '0;
        din     = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        @(negedge clk);
        n_vec++;
        if (fifo_din !== 16'h0000 || grant_id !== 2'd0 || fifo_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: din=%h grant=%0d wr_en=%b, required 0000/0/0", fifo_din, grant_id, fifo_wr_en);
        end
        req = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: wr_en=%b ack=%b, required 0/0000", fifo_wr_en, ack);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (ack !== (4'b0001 << exp_port[i]) || fifo_din !== (16'h1000 + 16'(exp_port[i]))) begin
                n_err++;
                $display("FAIL reset_seq[%0d]: ack=%b din=%h, required port %0d", i, ack, fifo_din, exp_port[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        din[2*DW +: DW] = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (fifo_wr_en !== 1'b1 || fifo_din !== 16'hA5A5 || ack !== 4'b0100 || grant_id !== 2'd2) begin
                n_err++;
                $display("FAIL single[%0d]: wr_en=%b din=%h ack=%b grant=%0d, required 1/a5a5/0100/2",
                         i, fifo_wr_en, fifo_din, ack, grant_id);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        req     = 4'b1111;
        tb_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin
                n_err++;
                $display("FAIL full[%0d]: wr_en=%b ack=%b, required 0/0000", i, fifo_wr_en, ack);
            end
            @(posedge clk); #1;
        end
        tb_full = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ack !== 4'b1000) begin
            n_err++;
            $display("FAIL full_release: ack=%b, required 1000", ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0] exp_ack[3];
        exp_ack = '{4'b0010, 4'b1000, 4'b0010};
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (ack !== exp_ack[i]) begin
                n_err++;
                $display("FAIL wrap[%0d]: ack=%b, required %b", i, ack, exp_ack[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_req();
        req = 4'b0000;
        @(negedge clk);
        n_vec++;
        if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || fifo_din !== 16'h0000) begin
            n_err++;
            $display("FAIL no_req: wr_en=%b ack=%b din=%h, required 0/0000/0000", fifo_wr_en, ack, fifo_din);
        end
        @(posedge clk); #1;
        req = 4'b1111;
        @(negedge clk);
        n_vec++;
        if (ack !== 4'b0100) begin
            n_err++;
            $display("FAIL no_req_resume: ack=%b, required 0100", ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        req = 4'b1111;
        @(negedge clk);
        n_vec++;
        if (ack !== 4'b1000) begin
            n_err++;
            $display("FAIL mid_pre: ack=%b, required 1000", ack);
        end
        @(posedge clk); #1;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: wr_en=%b ack=%b, required 0/0000", fifo_wr_en, ack);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ack !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_restart: ack=%b, required 0001", ack);
        end
        @(posedge clk); #1;
    endtask

`ifdef FIFO_ARB_BURST_EN
    task automatic test_burst();
        logic [N-1:0] t_req[9];
        logic         t_full[9];
        logic [N-1:0] t_ack[9];
        t_req  = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
        t_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t_ack  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0001};
        req = '0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req     = t_req[i];
            tb_full = t_full[i];
            @(negedge clk);
            n_vec++;
            if (ack !== t_ack[i]) begin
                n_err++;
                $display("FAIL burst[%0d]: ack=%b, required %b", i, ack, t_ack[i]);
            end
            @(posedge clk); #1;
        end
        tb_full = 1'b0;
    endtask
`endif

    task automatic test_end_to_end();
        int           sent[N];
        logic [N-1:0] a;
        bit           done;
        req = '0;
        do_reset();
        for (int k = 0; k < N; k++) begin
            sent[k]    = 0;
            exp_seq[k] = 0;
        end
        e2e_mode = 1'b1;
        done     = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            a = ack;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (a[k]) begin
                    sent[k]++;
                    req[k] = 1'b0;
                end
                if (!req[k] && sent[k] < WORDS && $urandom_range(0, 3) != 0) begin
                    din[k*DW +: DW] = {4'(k), 12'(sent[k])};
                    req[k] = 1'b1;
                end
            end
            done = (q.size() == 0);
            for (int k = 0; k < N; k++) begin
                if (sent[k] != WORDS) done = 1'b0;
            end
        end
        e2e_mode = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL e2e_timeout: run did not drain within cycle budget, queue=%0d", q.size());
        end
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (exp_seq[k] != WORDS) begin
                n_err++;
                $display("FAIL e2e_count[%0d]: read %0d words, required %0d", k, exp_seq[k], WORDS);
            end
        end
        req = '0;
    endtask

    initial begin
        rstn = 1'b0;
        req  = '0;
        din  = '0;
        test_reset();
`ifdef FIFO_ARB_BURST_EN
        test_burst();
`else
        test_single();
        test_backpressure();
        test_wrap_skip();
        test_no_req();
        test_mid_reset();
`endif
        test_end_to_end();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port (16-bit data, `wr_en`/`full`) between `N` producers. Each producer holds a request and its data word until acknowledged. The arbiter selects one producer per cycle, drives the FIFO write port and returns a one-cycle acknowledge. It sits directly in front of `sync_fifo` and is the only block that drives its `wr_en`/`din`.

## Interface

Parameters:
- `N`, 4: number of producers, 2..8.
- `DW`, 16: data width; matches `sync_fifo` `din`.
- `BURST_LEN`, 4: maximum consecutive words per lock when `FIFO_ARB_BURST_EN` is defined; 1..15.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req`  in  N  per-producer request; held high with data stable until `ack` of that bit.
- `din`  in  N*DW  flattened producer data; port k occupies bits `[k*DW +: DW]`.
- `ack`  out  N  one-hot; bit k high for the single cycle in which port k's word is written.
- `fifo_full`  in  1  from `sync_fifo` `full`.
- `fifo_wr_en`  out  1  to `sync_fifo` `wr_en`.
- `fifo_din`  out  DW  to `sync_fifo` `din`.
- `grant_id`  out  $clog2(N)  index of the currently selected port; valid when `|req`.

## Operation

- State registers:
  - `last` ($clog2(N) bits): index of the last winner; reset value `N-1`.
  - `st`: `IDLE` or `LOCK`; reset value `IDLE`.
  - `bcnt` (4 bits): burst counter; reset value 0.
- Selection in `IDLE`: the first asserted `req` bit, scanning upward from `(last+1) mod N` and wrapping.
- Selection in `LOCK`: the owner recorded in `last`, as long as `req[last]` is high.
- Write path (combinational from state and inputs):
  - `fifo_wr_en = |req & ~fifo_full & rstn`.
  - `fifo_din` = selected port's data. When no request is asserted, `fifo_din` = 0.
  - `ack` = one-hot of the selected port, qualified by `fifo_wr_en`.
- Accepted word (rising edge with `fifo_wr_en` = 1): `last` ← selected index.
- `fifo_full` = 1: no write and no ack; all state holds, including `LOCK` ownership and `bcnt`.
- No request: state holds, except that `LOCK` returns to `IDLE`.
- Requester protocol: a producer may not drop `req` before its `ack`. If it does, the word is simply not written; the arbiter has no error output.
- Fairness: with all N ports requesting continuously and the FIFO never full, each port gets exactly one word in every N accepted words (`BURST_LEN` words with bursts enabled).

## Timing

- Grant-to-write latency: 0 cycles. A request present on a rising edge with `fifo_full` = 0 is written on that same edge, with `ack` high in that cycle.
- Throughput: one word per cycle while `fifo_full` = 0.
- `fifo_full` is used as sampled. The FIFO asserts `full` from its own registered count, so no lookahead is needed.
- Reset values, during `rstn` = 0 and immediately after it:
  - `fifo_wr_en` = 0, `ack` = 0, `fifo_din` = 0 when no request.
  - `grant_id` = 0 when no request.
  - `st` = `IDLE`, `last` = N-1, `bcnt` = 0.
- Reset asserted mid-burst: outputs drop asynchronously in the same cycle. The first post-reset selection starts at port 0.
- Pointer wrap: when `last` = N-1, the scan starts at port 0.

## Configuration

`FIFO_ARB_BURST_EN`:
- Defined:
  - A word accepted from port k in `IDLE` enters `LOCK` with owner k and `bcnt` = 1.
  - While in `LOCK`, if `req[k]` stays high, port k keeps the grant regardless of other requests. Each accepted word increments `bcnt`.
  - The word that makes `bcnt` = `BURST_LEN` returns the arbiter to `IDLE`. The next selection scans from k+1.
  - `req[k]` low in `LOCK` returns the arbiter to `IDLE` on that edge without a write; `bcnt` is cleared.
  - `BURST_LEN` = 1 gives the same behaviour as when the macro is not defined.
- Not defined: `st` is always `IDLE` and `bcnt` is unused (constant 0). Arbitration is per-word round-robin.

## Test plan

- Reset: `rstn` = 0 with `req` = 4'b1111 → `fifo_wr_en` = 0 and `ack` = 0. Release reset → first acks go to 0,1,2,3,0, one per cycle.
- Single requester: `req` = 4'b0100 with `din[2]` = 16'hA5A5 → `fifo_wr_en` = 1, `fifo_din` = 16'hA5A5, `ack` = 4'b0100 on every cycle the request is held.
- Backpressure: all ports requesting and `fifo_full` = 1 for 3 cycles → no write and no ack during those cycles. On the first cycle after `full` deasserts, the port next in rotation (unchanged from before the stall) is written.
- Wrap and skip: `last` = 3 with `req` = 4'b1010 → port 1 wins, then port 3, then port 1.
- Burst (macro defined, `BURST_LEN` = 4): ports 0 and 1 requesting continuously → acks 0,0,0,0,1,1,1,1,0.
  - Port 0 drops `req` after 2 words → port 1 wins on the next cycle.
  - A `fifo_full` stall mid-burst does not change `bcnt`.
- End-to-end: four producers each write 50 random words into `sync_fifo` while a random-pace reader drains it → no word is lost or duplicated, and each port's words come out in that port's order.
